uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, log2 of queue depth; legal range 1..8.
REQ-002 SHALL derive DEPTH = 2**ADDR_W entries (default 16), each 8 bits.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port wr_ready  output  1  queue can accept a byte this cycle.
REQ-008 SHALL have port flush  input  1  discard all queued bytes.
REQ-009 SHALL have port tx_valid  output  1  tx_byte holds a valid head-of-queue byte.
REQ-010 SHALL have port tx_byte  output  8  head-of-queue byte toward the UART transmitter.
REQ-011 SHALL have port tx_ready  input  1  transmitter takes tx_byte this cycle (one-cycle strobe at TX_START entry).
REQ-012 SHALL have port count  output  ADDR_W+1  number of bytes held, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a write was offered while full.

Function
REQ-014 SHALL implement a first-word-fall-through circular buffer with read pointer, write pointer and registered count.
REQ-015 SHALL perform a push when wr_valid && wr_ready, storing wr_data at the write pointer and advancing it by one.
REQ-016 SHALL perform a pop when tx_valid && tx_ready, advancing the read pointer by one.
REQ-017 SHALL drive wr_ready = (count != DEPTH), independent of tx_ready (no push-through when full).
REQ-018 SHALL drive tx_valid = (count != 0) and tx_byte = entry at read pointer, combinationally from registered state.
REQ-019 SHALL present a byte pushed into an empty queue on tx_byte with tx_valid=1 on the cycle after the push (latency 1).
REQ-020 SHALL wrap both pointers modulo DEPTH (ADDR_W-bit natural rollover).
REQ-021 SHALL update count: push only +1, pop only -1, both or neither unchanged.
REQ-022 SHALL allow simultaneous push and pop when 0 < count < DEPTH; popped byte is the old head, pushed byte lands at tail.
REQ-023 SHALL ignore tx_ready while empty (no pointer or count change, no underflow).
REQ-024 SHALL ignore wr_valid while full (no write, no pointer change) and set overflow to 1 on that cycle's edge.
REQ-025 SHALL hold overflow at 1 until reset or flush.
REQ-026 SHALL on flush set both pointers and count to 0 and clear overflow, with priority over any push or pop in the same cycle.
REQ-027 SHALL leave storage array contents unchanged on flush and reset; only pointers/count define validity.
REQ-028 SHALL keep tx_byte stable while tx_valid=1 and no pop occurs.

Reset
REQ-029 SHALL on reset set read pointer, write pointer and count to 0 and overflow to 0, overriding flush, push and pop.
REQ-030 SHALL present after reset: wr_ready=1, tx_valid=0, count=0, overflow=0; tx_byte is don't-care while tx_valid=0.
REQ-031 SHALL discard all queued bytes when reset asserts mid-operation; first push after reset is stored at entry 0.

Verification
REQ-032 SHALL verify single byte: push 0x41 from reset -> next cycle tx_valid=1, tx_byte=0x41, count=1; tx_ready pulse -> next cycle tx_valid=0, count=0.
REQ-033 SHALL verify fill/order: push 0x00..0x0F (DEPTH=16) with tx_ready=0 -> count=16, wr_ready=0; then 16 tx_ready pulses pop 0x00..0x0F in order, count returns to 0.
REQ-034 SHALL verify overflow: at count=16 drive wr_valid with 0xFF -> count stays 16, overflow=1, 0xFF never appears on tx_byte; flush -> overflow=0, count=0.
REQ-035 SHALL verify simultaneous: count=3 (0x10,0x11,0x12), push 0x13 with tx_ready=1 -> count=3, tx_byte=0x11, later pops 0x12, 0x13.
REQ-036 SHALL verify wrap: 40 push/pop pairs of incrementing bytes with count held at 2 -> output sequence exactly matches input across pointer rollover.
REQ-037 SHALL verify priority: flush and push 0x55 same cycle -> count=0, tx_valid=0; reset during count=5 -> count=0, next push 0xA5 appears on tx_byte.

Source files
------------

// File: rtl/uart_tx_queue.sv
// First-word-fall-through byte queue feeding a UART transmitter.
// A circular buffer with read/write pointers, a registered count and a sticky overflow flag.
module uart_tx_queue #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              flush,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              push;
    logic              pop;

    // Full/empty and head byte come straight from registered state, so
    // wr_ready never depends on tx_ready (no push-through when full).
    assign wr_ready = (count_q != FULL_COUNT);
    assign tx_valid = (count_q != '0);
    assign tx_byte  = mem[rd_ptr];
    assign count    = count_q;
    assign overflow = overflow_q;

    assign push = wr_valid && wr_ready;
    assign pop  = tx_valid && tx_ready;

    // NOTE: the storage array has no reset; validity is defined purely by
    // the pointers and count, which keeps the array a plain RAM.
    always_ff @(posedge clock) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_valid && !wr_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus pushes expected bytes,
// a negedge monitor pops and compares every byte the DUT hands over.
module tb_uart_tx_queue;

    logic       clock;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       flush;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic [4:0] count;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q [$];

    uart_tx_queue #(.ADDR_W(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .flush    (flush),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready),
        .count    (count),
        .overflow (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop happens at the next rising edge when tx_valid && tx_ready.
    always @(negedge clock) begin
        if (!reset && !flush && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(tx_byte), 32'hDEAD);
            end else begin
                check("tx_order", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        wr_valid = 1'b1;
        wr_data  = b;
        if (accepted) exp_q.push_back(b);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pop_byte();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        flush    = 1'b0;
        tx_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single byte, latency 1
        push_byte(8'h41, 1'b1);
        check("single_tx_valid", 32'(tx_valid), 32'd1);
        check("single_tx_byte",  32'(tx_byte),  32'h41);
        check("single_count",    32'(count),    32'd1);
        pop_byte();
        check("single_empty_valid", 32'(tx_valid), 32'd0);
        check("single_empty_count", 32'(count),    32'd0);

        // Popping while empty is ignored
        pop_byte();
        check("underflow_count", 32'(count), 32'd0);

        // Fill and drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        check("fill_count",    32'(count),    32'd16);
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        check("fill_head",     32'(tx_byte),  32'h00);
        for (int i = 0; i < 16; i++) pop_byte();
        check("drain_count", 32'(count), 32'd0);

        // Overflow while full; 0xFF must never reach tx_byte
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b1);
        push_byte(8'hFF, 1'b0);
        check("ovf_count", 32'(count),    32'd16);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_head",  32'(tx_byte),  32'h20);
        step();
        check("ovf_sticky", 32'(overflow), 32'd1);
        pop_byte();
        check("ovf_after_pop_head", 32'(tx_byte), 32'h21);
        do_flush();
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_count",    32'(count),    32'd0);
        check("flush_tx_valid", 32'(tx_valid), 32'd0);

        // Simultaneous push and pop
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h12, 1'b1);
        check("simul_pre_count", 32'(count), 32'd3);
        wr_valid = 1'b1;
        wr_data  = 8'h13;
        tx_ready = 1'b1;
        exp_q.push_back(8'h13);
        step();
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        check("simul_count", 32'(count),   32'd3);
        check("simul_head",  32'(tx_byte), 32'h11);
        for (int i = 0; i < 3; i++) pop_byte();
        check("simul_drain", 32'(count), 32'd0);

        // Wrap: 40 push/pop pairs at count 2
        push_byte(8'h80, 1'b1);
        push_byte(8'h81, 1'b1);
        for (int i = 0; i < 40; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h82 + i);
            tx_ready = 1'b1;
            exp_q.push_back(8'(8'h82 + i));
            step();
        end
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        check("wrap_count", 32'(count),   32'd2);
        check("wrap_head",  32'(tx_byte), 32'hA8);
        pop_byte();
        pop_byte();
        check("wrap_drain", 32'(count), 32'd0);

        // Flush beats a push in the same cycle
        push_byte(8'h33, 1'b1);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        exp_q.delete();
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_prio_count", 32'(count),    32'd0);
        check("flush_prio_valid", 32'(tx_valid), 32'd0);

        // Reset mid-operation at count 5, then reset clears overflow
        for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i), 1'b1);
        check("pre_reset_count", 32'(count), 32'd5);
        do_reset();
        check("mid_reset_count", 32'(count),    32'd0);
        check("mid_reset_valid", 32'(tx_valid), 32'd0);
        push_byte(8'hA5, 1'b1);
        check("post_reset_valid", 32'(tx_valid), 32'd1);
        check("post_reset_byte",  32'(tx_byte),  32'hA5);
        pop_byte();
        for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i), 1'b1);
        push_byte(8'hFF, 1'b0);
        check("ovf2_flag", 32'(overflow), 32'd1);
        do_reset();
        check("reset_clears_ovf",   32'(overflow), 32'd0);
        check("reset_wr_ready",     32'(wr_ready), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
